// File: rtl/counter4_sched_pkg.sv
// Shared types and defaults for the two-requester scheduled down-counter.
package counter4_sched_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  // Round-robin pick between two requesters: returns 1 when requester 1 wins.
  // On a tie the requester that was not granted last time wins; a sole
  // requester always wins; with no request the result is unused.
  function automatic logic pick_winner(input logic r0, input logic r1, input logic last_gnt);
    return (r0 && r1) ? ~last_gnt : r1;
  endfunction

endpackage

// File: rtl/counter4_load_dn.sv
// Loadable, enabled down-counter that saturates at zero and flags zero.
module counter4_load_dn
  import counter4_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             zero
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Load has priority over counting; the count never goes below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en && (q != '0)) begin
      q <= q - ONE;
    end
  end

  assign zero = (q == '0);

endmodule

// File: rtl/counter4_sched.sv
// Two-requester round-robin scheduler sharing one timed down-counter.
// A grant lasts len+1 cycles (q = len..0); the edge that ends the final
// cycle, an aborted grant, or any edge in IDLE re-arbitrates.
module counter4_sched
  import counter4_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] len0,
  input  logic             req1,
  input  logic [WIDTH-1:0] len1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic [WIDTH-1:0] q
);

  state_t           state, state_nx;
  logic             owner, owner_nx;
  logic             last_gnt, last_gnt_nx;
  logic             load, dec_en, arb;
  logic             q_zero;
  logic             granted_req;
  logic             any_req;
  logic             winner;
  logic [WIDTH-1:0] load_val;

  assign granted_req = owner ? req1 : req0;
  assign any_req     = req0 | req1;
  assign winner      = pick_winner(req0, req1, last_gnt);
  assign load_val    = winner ? len1 : len0;

  // Next-state logic: decide whether this edge arbitrates, counts, or idles.
  always_comb begin
    state_nx    = state;
    owner_nx    = owner;
    last_gnt_nx = last_gnt;
    load        = 1'b0;
    dec_en      = 1'b0;
    arb         = 1'b0;
    case (state)
      IDLE:    arb = 1'b1;
      COUNT: begin
        if (!granted_req || q_zero) begin
          arb = 1'b1;
        end else begin
          dec_en = 1'b1;
        end
      end
      default: arb = 1'b1;
    endcase
    if (arb) begin
      if (any_req) begin
        state_nx    = COUNT;
        owner_nx    = winner;
        last_gnt_nx = winner;
        load        = 1'b1;
      end else begin
        state_nx = IDLE;
      end
    end
  end

  // State, owner and round-robin pointer; the pointer starts at requester 1
  // so requester 0 wins the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      last_gnt <= last_gnt_nx;
    end
  end

  counter4_load_dn #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .en      (dec_en),
    .load_val(load_val),
    .q       (q),
    .zero    (q_zero)
  );

  assign busy  = (state == COUNT);
  assign gnt0  = busy & ~owner;
  assign gnt1  = busy & owner;
  assign done0 = gnt0 & req0 & q_zero;
  assign done1 = gnt1 & req1 & q_zero;

endmodule

// File: tb/tb_counter4_sched.sv
// Self-checking bench for counter4_sched: directed scenarios plus random
// traffic, all compared against a behavioural scheduler model.
module tb_counter4_sched;

  logic       clk;
  logic       rst_n;
  logic       req0, req1;
  logic [3:0] len0, len1;
  logic       gnt0, gnt1, done0, done1, busy;
  logic [3:0] q;
  logic [8:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: owner index (-1 = idle), counter value, last winner.
  int m_owner;
  int m_q;
  int m_last;

  counter4_sched #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req0 (req0),
    .len0 (len0),
    .req1 (req1),
    .len1 (len1),
    .gnt0 (gnt0),
    .gnt1 (gnt1),
    .done0(done0),
    .done1(done1),
    .busy (busy),
    .q    (q)
  );

  assign obs = {busy, gnt0, gnt1, done0, done1, q};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_owner = -1;
    m_q     = 0;
    m_last  = 1;
  endtask

  // Apply the scheduling rules for one rising edge using current inputs.
  task automatic model_edge();
    bit rearb;
    int w;
    rearb = 0;
    if (m_owner < 0) rearb = 1;
    else if (((m_owner == 0) ? req0 : req1) == 1'b0) rearb = 1;
    else if (m_q == 0) rearb = 1;
    else m_q = m_q - 1;
    if (rearb) begin
      if (req0 && req1) w = (m_last == 0) ? 1 : 0;
      else if (req0) w = 0;
      else if (req1) w = 1;
      else w = -1;
      m_owner = w;
      if (w >= 0) begin
        m_last = w;
        m_q    = (w == 0) ? int'(len0) : int'(len1);
      end
    end
  endtask

  function automatic logic [8:0] model_out();
    logic b, g0, g1, d0, d1;
    b  = (m_owner >= 0);
    g0 = (m_owner == 0);
    g1 = (m_owner == 1);
    d0 = g0 && req0 && (m_q == 0);
    d1 = g1 && req1 && (m_q == 0);
    return {b, g0, g1, d0, d1, 4'(m_q)};
  endfunction

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 0; req1 = 0; len0 = 0; len1 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs !== 9'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %b expected %b", obs, 9'b0);
    end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_single();
    logic [5:0] want;
    req0 = 1; len0 = 4'd3;
    cycle();
    for (int i = 0; i < 4; i++) begin
      #1;
      want = {1'b1, 1'b0, (i == 3), 3'(3 - i)};
      n_checks++;
      if (obs !== model_out()) begin
        n_fail++;
        $display("[TB] FAIL single_model cyc %0d: got %b expected %b", i, obs, model_out());
      end
      n_checks++;
      if ({gnt0, gnt1, done0, q[2:0]} !== want) begin
        n_fail++;
        $display("[TB] FAIL single_seq cyc %0d: got %b expected %b", i, {gnt0, gnt1, done0, q[2:0]}, want);
      end
      if (i == 3) req0 = 0;
      cycle();
    end
    n_checks++;
    if ({busy, gnt0, gnt1} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL single_idle: got %b expected 000", {busy, gnt0, gnt1});
    end
  endtask

  task automatic test_tie();
    int own_tab [8] = '{0, 0, 0, 1, 1, 0, 0, 0};
    int q_tab   [8] = '{2, 1, 0, 1, 0, 2, 1, 0};
    logic [5:0] want;
    rst_n = 0; #1; model_reset(); rst_n = 1; #1;
    req0 = 1; req1 = 1; len0 = 4'd2; len1 = 4'd1;
    cycle();
    for (int i = 0; i < 8; i++) begin
      #1;
      want = {(own_tab[i] == 0), (own_tab[i] == 1),
              (own_tab[i] == 0) && (q_tab[i] == 0),
              (own_tab[i] == 1) && (q_tab[i] == 0), 2'(q_tab[i])};
      n_checks++;
      if (obs !== model_out()) begin
        n_fail++;
        $display("[TB] FAIL tie_model cyc %0d: got %b expected %b", i, obs, model_out());
      end
      n_checks++;
      if ({gnt0, gnt1, done0, done1, q[1:0]} !== want || q[3:2] !== 2'b00) begin
        n_fail++;
        $display("[TB] FAIL tie_seq cyc %0d: got %b/%0d expected %b", i, {gnt0, gnt1, done0, done1}, q, want);
      end
      cycle();
    end
    req0 = 0; req1 = 0;
    cycle();
    #1;
    n_checks++;
    if (obs !== model_out() || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL tie_idle: got %b expected %b", obs, model_out());
    end
  endtask

  task automatic test_len_zero();
    req1 = 1; len1 = 4'd0;
    cycle();
    #1;
    n_checks++;
    if ({gnt0, gnt1, done0, done1, q} !== {4'b0101, 4'd0} || obs !== model_out()) begin
      n_fail++;
      $display("[TB] FAIL len_zero: got %b expected %b", obs, model_out());
    end
    req1 = 0;
    cycle();
    n_checks++;
    if (busy !== 1'b0 || obs !== model_out()) begin
      n_fail++;
      $display("[TB] FAIL len_zero_idle: got %b expected %b", obs, model_out());
    end
  endtask

  task automatic test_abort();
    req0 = 1; len0 = 4'd9;
    cycle();
    repeat (4) cycle();
    n_checks++;
    if (q !== 4'd5 || gnt0 !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL abort_q5: got q=%0d gnt0=%b expected q=5 gnt0=1", q, gnt0);
    end
    req0 = 0; req1 = 1; len1 = 4'd2;
    #1;
    n_checks++;
    if (done0 !== 1'b0 || obs !== model_out()) begin
      n_fail++;
      $display("[TB] FAIL abort_nodone: got %b expected %b", obs, model_out());
    end
    cycle();
    n_checks++;
    if ({gnt0, gnt1, q} !== {2'b01, 4'd2} || obs !== model_out()) begin
      n_fail++;
      $display("[TB] FAIL abort_handover: got %b expected %b", obs, model_out());
    end
    req1 = 0;
    cycle();
  endtask

  task automatic test_reset_mid();
    req0 = 1; len0 = 4'd9;
    cycle();
    repeat (3) cycle();
    n_checks++;
    if (q !== 4'd6 || gnt0 !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rstmid_q6: got q=%0d gnt0=%b expected q=6 gnt0=1", q, gnt0);
    end
    rst_n = 0;
    #1;
    model_reset();
    n_checks++;
    if (obs !== 9'b0) begin
      n_fail++;
      $display("[TB] FAIL rstmid_async: got %b expected %b", obs, 9'b0);
    end
    @(posedge clk);
    #1;
    rst_n = 1; req0 = 1; req1 = 1; len0 = 4'd1; len1 = 4'd1;
    #1;
    cycle();
    n_checks++;
    if ({gnt0, gnt1, q} !== {2'b10, 4'd1} || obs !== model_out()) begin
      n_fail++;
      $display("[TB] FAIL rstmid_first_tie: got %b expected %b", obs, model_out());
    end
    req0 = 0; req1 = 0;
    cycle();
  endtask

  task automatic test_len_change();
    req0 = 1; len0 = 4'd7;
    cycle();
    len0 = 4'd2;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_checks++;
      if (q !== 4'(7 - i) || gnt0 !== 1'b1 || done0 !== (i == 7) || obs !== model_out()) begin
        n_fail++;
        $display("[TB] FAIL len_change cyc %0d: got %b expected q=%0d", i, obs, 7 - i);
      end
      if (i == 7) req0 = 0;
      cycle();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req0 = ~req0;
      if ($urandom_range(0, 3) == 0) req1 = ~req1;
      len0 = 4'($urandom_range(0, 15));
      len1 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 79) == 0) begin
        rst_n = 0;
        #1;
        model_reset();
        n_checks++;
        if (obs !== 9'b0) begin
          n_fail++;
          $display("[TB] FAIL random_reset cyc %0d: got %b expected %b", i, obs, 9'b0);
        end
        rst_n = 1;
      end
      #1;
      n_checks++;
      if (obs !== model_out()) begin
        n_fail++;
        $display("[TB] FAIL random cyc %0d: got %b expected %b (req=%b%b)", i, obs, model_out(), req1, req0);
      end
      cycle();
    end
    req0 = 0; req1 = 0;
    cycle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_len_zero();
    test_abort();
    test_reset_mid();
    test_len_change();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
